stream_output_arbiter: RTL and testbench
========================================

# stream_output_arbiter

Packet-granular round-robin arbiter sharing one AXI-Stream master output between two detector result streams (e.g. two parallel target-detection cores). Each requester presents words with a valid flag and receives a STOP_PIPELINE backpressure signal in the same style as the existing output stage. The arbiter grants one requester for a whole packet of PACKET_LEN words, marks the last word with TLAST, tags each word with its source, then re-arbitrates.

## Interface
- DATA_WIDTH, 32, word width of requester data and M_AXIS_TDATA
- PACKET_LEN, 100, words per packet (≥2)
- CNT_WIDTH, 16, width of word counter and stats counters; 2^CNT_WIDTH > PACKET_LEN
- CLK  in  1  clock; one clock, all logic on rising edge
- RESET  in  1  reset, synchronous and active-high
- DATA_IN_0  in  DATA_WIDTH  requester 0 data
- DATA_IN_VALID_0  in  1  requester 0 word present
- STOP_PIPELINE_0  out  1  requester 0 must hold its word (not consumed this cycle)
- DATA_IN_1  in  DATA_WIDTH  requester 1 data
- DATA_IN_VALID_1  in  1  requester 1 word present
- STOP_PIPELINE_1  out  1  requester 1 must hold its word
- M_AXIS_TDATA  out  DATA_WIDTH  output data
- M_AXIS_TVALID  out  1  output word valid
- M_AXIS_TLAST  out  1  last word of packet
- M_AXIS_TUSER  out  1  source id of current word (0/1)
- M_AXIS_TREADY  in  1  downstream ready
- PKT_CNT_0, PKT_CNT_1  out  CNT_WIDTH  completed packets per source (only with ARB_STATS_EN)

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Register prio (next-preferred source), word counter wcnt, one-entry output register (TDATA/TUSER/TLAST/TVALID).
- IDLE: if exactly one DATA_IN_VALID_x high → GRANTx. If both high → GRANT<prio>. Neither → stay IDLE. No word accepted in IDLE.
- Accept condition in GRANTx: acc = DATA_IN_VALID_x && (!M_AXIS_TVALID || M_AXIS_TREADY). On acc: output register loads DATA_IN_x, TUSER=x, TLAST=(wcnt==PACKET_LEN-1), TVALID=1; wcnt increments.
- On acc with wcnt==PACKET_LEN-1: wcnt←0, prio←~x, state←IDLE.
- If TVALID && TREADY && !acc: TVALID←0.
- STOP_PIPELINE_x = !(state==GRANTx && (!M_AXIS_TVALID || M_AXIS_TREADY)); combinational. Non-granted requester always sees STOP_PIPELINE=1. A requester's word is consumed exactly when its VALID=1 and STOP_PIPELINE=0.
- Grant is never revoked mid-packet: granted requester with VALID low stalls the output (TVALID drops after drain); other requester waits.
- Output register holds TDATA/TUSER/TLAST stable while TVALID && !TREADY.

## Timing
- Reset values: state=IDLE, prio=0, wcnt=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TUSER=0, STOP_PIPELINE_0/1=1, PKT_CNT_0/1=0.
- RESET mid-packet: partial packet discarded, no TLAST emitted; output register cleared next edge.
- Latency: valid at cycle N in IDLE → grant at N+1 → first word on M_AXIS at N+2. Within packet, one word per cycle when TREADY=1 continuously.
- Re-arbitration costs exactly one IDLE cycle between packets (no accept, no STOP release).
- Throughput with TREADY=1 and both requesters busy: PACKET_LEN words per PACKET_LEN+1 cycles.
- TREADY low: TVALID held, STOP_PIPELINE of granted source goes high same cycle; resumes same cycle TREADY returns.

## Configuration
- ARB_STATS_EN defined: PKT_CNT_0/PKT_CNT_1 ports present; PKT_CNT_x increments on the acc that carries TLAST for source x; wraps modulo 2^CNT_WIDTH.
- ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Only source 0 valid continuously, TREADY=1, PACKET_LEN=4, data 1,2,3,…: → TDATA 1..4 TUSER=0 TLAST on 4th, one-cycle gap, 5..8 next packet; first word 2 cycles after first valid.
- Both sources valid from reset, TREADY=1: packets alternate 0,1,0,1 starting with 0; STOP_PIPELINE_1=1 throughout every source-0 packet.
- TREADY low for 10 cycles mid-packet: TDATA/TLAST stable, STOP_PIPELINE of granted source =1 for those cycles, no word lost or duplicated (output sequence strictly +1).
- Granted source drops VALID for 5 cycles mid-packet while other source valid: no switch; packet completes with exactly PACKET_LEN words before source switches.
- RESET asserted for one cycle in middle of packet: next cycle TVALID=0, STOP_PIPELINE_0/1=1; following packet starts wcnt=0 with source 0.
- ARB_STATS_EN, 3 packets per source alternating: PKT_CNT_0=3, PKT_CNT_1=3; each increments in the cycle after its TLAST word is accepted into the output register.

Source files
------------

// File: rtl/stream_output_arbiter_if.sv
// Bus bundle for stream_output_arbiter: two requester streams with
// STOP_PIPELINE backpressure and one AXI-Stream master output.
//   master : arbiter side (drives STOP_PIPELINE_x and M_AXIS_T*)
//   slave  : environment side (drives DATA_IN_x, DATA_IN_VALID_x, M_AXIS_TREADY)
// With ARB_STATS_EN defined the per-source packet counters PKT_CNT_0/1 are added.
interface stream_output_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] DATA_IN_0;
    logic                  DATA_IN_VALID_0;
    logic                  STOP_PIPELINE_0;
    logic [DATA_WIDTH-1:0] DATA_IN_1;
    logic                  DATA_IN_VALID_1;
    logic                  STOP_PIPELINE_1;
    logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TLAST;
    logic                  M_AXIS_TUSER;
    logic                  M_AXIS_TREADY;
`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0]  PKT_CNT_0;
    logic [CNT_WIDTH-1:0]  PKT_CNT_1;
`endif

    modport master (
        input  DATA_IN_0, DATA_IN_VALID_0, DATA_IN_1, DATA_IN_VALID_1, M_AXIS_TREADY,
        output STOP_PIPELINE_0, STOP_PIPELINE_1,
        output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER
`ifdef ARB_STATS_EN
        , output PKT_CNT_0, PKT_CNT_1
`endif
    );

    modport slave (
        output DATA_IN_0, DATA_IN_VALID_0, DATA_IN_1, DATA_IN_VALID_1, M_AXIS_TREADY,
        input  STOP_PIPELINE_0, STOP_PIPELINE_1,
        input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER
`ifdef ARB_STATS_EN
        , input PKT_CNT_0, PKT_CNT_1
`endif
    );
endinterface

// File: rtl/stream_output_arbiter.sv
// Packet-granular round-robin arbiter: two requester streams share one
// AXI-Stream output. A grant lasts exactly PACKET_LEN accepted words, the last
// word carries TLAST, TUSER carries the source id, then one IDLE cycle follows.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : stream_output_arbiter_if.master (requester inputs, STOP_PIPELINE_x,
//                M_AXIS_T* output register, optional PKT_CNT_x)
// Optional feature macro: ARB_STATS_EN (per-source completed packet counters).
module stream_output_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PACKET_LEN = 100,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    stream_output_arbiter_if.master bus
);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PACKET_LEN - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;

    logic out_free_c;
    logic acc0_c, acc1_c, acc_c, last_c;

    // Output register can take a word when empty or being drained this cycle.
    assign out_free_c = !tvalid_q || bus.M_AXIS_TREADY;
    assign acc0_c     = (state_q == GRANT0) && bus.DATA_IN_VALID_0 && out_free_c;
    assign acc1_c     = (state_q == GRANT1) && bus.DATA_IN_VALID_1 && out_free_c;
    assign acc_c      = acc0_c || acc1_c;
    assign last_c     = (wcnt_q == LAST_IDX);

    // Next-state, arbitration and output-register load.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        wcnt_d   = wcnt_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        case (state_q)
            IDLE: begin
                if (bus.DATA_IN_VALID_0 && bus.DATA_IN_VALID_1)
                    state_d = prio_q ? GRANT1 : GRANT0;
                else if (bus.DATA_IN_VALID_0)
                    state_d = GRANT0;
                else if (bus.DATA_IN_VALID_1)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (acc0_c && last_c) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end
            GRANT1: begin
                if (acc1_c && last_c) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc_c) begin
            tdata_d  = acc1_c ? bus.DATA_IN_1 : bus.DATA_IN_0;
            tuser_d  = acc1_c;
            tlast_d  = last_c;
            tvalid_d = 1'b1;
            wcnt_d   = last_c ? '0 : wcnt_q + CNT_WIDTH'(1);
        end else if (tvalid_q && bus.M_AXIS_TREADY) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            wcnt_q   <= '0;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            wcnt_q   <= wcnt_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    // Backpressure is combinational so the requester sees it in the same cycle.
    assign bus.STOP_PIPELINE_0 = !((state_q == GRANT0) && out_free_c);
    assign bus.STOP_PIPELINE_1 = !((state_q == GRANT1) && out_free_c);

    assign bus.M_AXIS_TDATA  = tdata_q;
    assign bus.M_AXIS_TUSER  = tuser_q;
    assign bus.M_AXIS_TLAST  = tlast_q;
    assign bus.M_AXIS_TVALID = tvalid_q;

`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt1_q;

    // Count a packet when its TLAST word enters the output register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            if (acc0_c && last_c) pkt_cnt0_q <= pkt_cnt0_q + CNT_WIDTH'(1);
            if (acc1_c && last_c) pkt_cnt1_q <= pkt_cnt1_q + CNT_WIDTH'(1);
        end
    end

    assign bus.PKT_CNT_0 = pkt_cnt0_q;
    assign bus.PKT_CNT_1 = pkt_cnt1_q;
`else
    // Statistics counters are not built.
`endif
endmodule

// File: tb/tb_stream_output_arbiter.sv
// Directed bench for stream_output_arbiter with PACKET_LEN=4. Source 0 sends
// words 1,2,3,... and source 1 sends 1001,1002,...; output words are logged at
// the falling edge and compared against hand-computed sequences.
module tb_stream_output_arbiter;
    localparam int unsigned DW  = 32;
    localparam int unsigned PL  = 4;
    localparam int unsigned CW  = 16;

    logic clk;
    logic rst;

    stream_output_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    stream_output_arbiter #(.DATA_WIDTH(DW), .PACKET_LEN(PL), .CNT_WIDTH(CW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_data[$];
    logic        q_user[$];
    logic        q_last[$];
    int          q_cyc[$];

    int          cyc;
    logic [31:0] d0, d1;
    int          open0, open1, both_open;
    logic        s_tvalid, s_tlast, s_tuser, s_stop0, s_stop1, s_fire;
    logic [31:0] s_tdata;
    logic [31:0] d0_snap;
`ifdef ARB_STATS_EN
    logic [15:0] s_pc0, s_pc1;
    int          lasts0, lasts1;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, advance the sources after the rising edge.
    task automatic tick();
        logic c0, c1;
        @(negedge clk);
        s_tvalid = bus.M_AXIS_TVALID;
        s_tdata  = bus.M_AXIS_TDATA;
        s_tlast  = bus.M_AXIS_TLAST;
        s_tuser  = bus.M_AXIS_TUSER;
        s_stop0  = bus.STOP_PIPELINE_0;
        s_stop1  = bus.STOP_PIPELINE_1;
`ifdef ARB_STATS_EN
        s_pc0    = bus.PKT_CNT_0;
        s_pc1    = bus.PKT_CNT_1;
`endif
        s_fire   = bus.M_AXIS_TVALID && bus.M_AXIS_TREADY;
        if (s_fire) begin
            q_data.push_back(s_tdata);
            q_user.push_back(s_tuser);
            q_last.push_back(s_tlast);
            q_cyc.push_back(cyc);
        end
        c0 = bus.DATA_IN_VALID_0 && !s_stop0;
        c1 = bus.DATA_IN_VALID_1 && !s_stop1;
        if (!s_stop0) open0++;
        if (!s_stop1) open1++;
        if (!s_stop0 && !s_stop1) both_open++;
        @(posedge clk);
        #1;
        if (c0) d0 = d0 + 1;
        if (c1) d1 = d1 + 1;
        bus.DATA_IN_0 = d0;
        bus.DATA_IN_1 = d1;
        cyc++;
    endtask

    task automatic clear_log();
        q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
        open0 = 0; open1 = 0; both_open = 0; cyc = 0;
    endtask

    // One reset cycle, then restart both sources from their first word.
    task automatic do_reset(input logic v0, input logic v1);
        bus.DATA_IN_VALID_0 = v0;
        bus.DATA_IN_VALID_1 = v1;
        bus.M_AXIS_TREADY   = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = 1; d1 = 1001;
        bus.DATA_IN_0 = d0;
        bus.DATA_IN_1 = d1;
        clear_log();
    endtask

    task automatic wait_fires(input string tag, input int n);
        for (int i = 0; i < 200 && q_data.size() < n; i++) tick();
        chk(tag, 32'(q_data.size() >= n), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        d0 = 1; d1 = 1001; cyc = 0;
        bus.DATA_IN_0 = d0; bus.DATA_IN_1 = d1;
        bus.DATA_IN_VALID_0 = 1'b0; bus.DATA_IN_VALID_1 = 1'b0;
        bus.M_AXIS_TREADY = 1'b1;
        tick(); tick();

        // Reset state and single-source packets with first-word latency.
        do_reset(1'b0, 1'b0);
        tick();
        chk("rst_tvalid", 32'(s_tvalid), 32'd0);
        chk("rst_tdata",  s_tdata,       32'd0);
        chk("rst_tlast",  32'(s_tlast),  32'd0);
        chk("rst_tuser",  32'(s_tuser),  32'd0);
        chk("rst_stop0",  32'(s_stop0),  32'd1);
        chk("rst_stop1",  32'(s_stop1),  32'd1);
`ifdef ARB_STATS_EN
        chk("rst_pc0", 32'(s_pc0), 32'd0);
        chk("rst_pc1", 32'(s_pc1), 32'd0);
`endif
        clear_log();
        bus.DATA_IN_VALID_0 = 1'b1;
        tick();
        chk("lat_n_tvalid", 32'(s_tvalid), 32'd0);
        chk("lat_n_stop0",  32'(s_stop0),  32'd1);
        tick();
        chk("lat_n1_tvalid", 32'(s_tvalid), 32'd0);
        chk("lat_n1_stop0",  32'(s_stop0),  32'd0);
        tick();
        chk("lat_n2_tvalid", 32'(s_tvalid), 32'd1);
        chk("lat_n2_tdata",  s_tdata,       32'd1);
        wait_fires("t1_fires", 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_data", q_data[i], 32'(i + 1));
            chk("t1_user", 32'(q_user[i]), 32'd0);
            chk("t1_last", 32'(q_last[i]), 32'((i % 4) == 3));
        end
        chk("t1_burst", 32'(q_cyc[3] - q_cyc[0]), 32'd3);
        chk("t1_gap",   32'(q_cyc[4] - q_cyc[3]), 32'd2);

        // Both sources busy from reset: alternate 0,1,0,1 with one idle cycle.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 26; i++) tick();
        chk("t2_fires", 32'(q_data.size()), 32'd20);
        for (int p = 0; p < 4; p++) begin
            chk("t2_user",  32'(q_user[p*4]),   32'(p % 2));
            chk("t2_first", q_data[p*4],        (p % 2 == 1) ? 32'(1001 + (p/2)*4) : 32'(1 + (p/2)*4));
            chk("t2_last",  32'(q_last[p*4+3]), 32'd1);
            chk("t2_nlast", 32'(q_last[p*4+2]), 32'd0);
        end
        chk("t2_period",    32'(q_cyc[4] - q_cyc[0]), 32'd5);
        chk("t2_open0",     32'(open0),     32'd12);
        chk("t2_open1",     32'(open1),     32'd8);
        chk("t2_both_open", 32'(both_open), 32'd0);

        // TREADY low for 10 cycles mid-packet: word 3 held, no loss or duplicate.
        do_reset(1'b1, 1'b0);
        wait_fires("t3_pre", 2);
        bus.M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_tvalid", 32'(s_tvalid), 32'd1);
            chk("t3_tdata",  s_tdata,       32'd3);
            chk("t3_tlast",  32'(s_tlast),  32'd0);
            chk("t3_stop0",  32'(s_stop0),  32'd1);
        end
        bus.M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("t3_fires", 32'(q_data.size() >= 10), 32'd1);
        for (int i = 0; i < q_data.size(); i++) begin
            chk("t3_seq",  q_data[i],         32'(i + 1));
            chk("t3_last", 32'(q_last[i]),    32'(((i + 1) % 4) == 0));
        end

        // Granted source pauses mid-packet: no switch until its packet completes.
        do_reset(1'b1, 1'b1);
        wait_fires("t4_pre", 2);
        bus.DATA_IN_VALID_0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stop1", 32'(s_stop1), 32'd1);
        end
        bus.DATA_IN_VALID_0 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_data", q_data[i],         32'(i + 1));
            chk("t4_user", 32'(q_user[i]),    32'd0);
        end
        chk("t4_last",   32'(q_last[3]), 32'd1);
        chk("t4_switch", 32'(q_user[4]), 32'd1);
        chk("t4_next",   q_data[4],      32'd1001);

        // Reset in the middle of a packet: partial packet dropped, restart on source 0.
        do_reset(1'b1, 1'b1);
        wait_fires("t5_pre", 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        tick();
        chk("t5_tvalid", 32'(s_tvalid), 32'd0);
        chk("t5_stop0",  32'(s_stop0),  32'd1);
        chk("t5_stop1",  32'(s_stop1),  32'd1);
        d0_snap = d0;
        for (int i = 0; i < 12; i++) tick();
        chk("t5_first", q_data[0], d0_snap);
        for (int i = 0; i < 4; i++) begin
            chk("t5_user", 32'(q_user[i]), 32'd0);
            chk("t5_last", 32'(q_last[i]), 32'(i == 3));
        end
        chk("t5_switch", 32'(q_user[4]), 32'd1);

`ifdef ARB_STATS_EN
        // Three packets per source: counter visible alongside its TLAST word.
        do_reset(1'b1, 1'b1);
        lasts0 = 0; lasts1 = 0;
        for (int i = 0; i < 200 && (lasts0 + lasts1) < 6; i++) begin
            tick();
            if (s_fire && s_tlast) begin
                if (s_tuser) begin
                    lasts1++;
                    chk("t6_pc1_step", 32'(s_pc1), 32'(lasts1));
                end else begin
                    lasts0++;
                    chk("t6_pc0_step", 32'(s_pc0), 32'(lasts0));
                end
            end
        end
        tick();
        chk("t6_pc0", 32'(s_pc0), 32'd3);
        chk("t6_pc1", 32'(s_pc1), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
